// File: rtl/pipe_hazard_unit_if.sv
// ID-stage request and hazard-control response bundle for pipe_hazard_unit.
// The master side is the pipeline. The slave side is the hazard/forwarding controller.
interface pipe_hazard_unit_if #(
    parameter int AW    = 5,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [AW-1:0]    id_rs1;
    logic [AW-1:0]    id_rs2;
    logic             id_use1;
    logic             id_use2;
    logic [AW-1:0]    id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic             id_branch;
    logic             br_taken;

    logic             stall;
    logic             flush_ifid;
    logic             flush_idex;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [1:0]       idfwd_a;
    logic [1:0]       idfwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use1, id_use2, id_rd,
               id_regwrite, id_memread, id_branch, br_taken,
        input  stall, flush_ifid, flush_idex, fwd_a, fwd_b,
               idfwd_a, idfwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use1, id_use2, id_rd,
               id_regwrite, id_memread, id_branch, br_taken,
        output stall, flush_ifid, flush_idex, fwd_a, fwd_b,
               idfwd_a, idfwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Hazard detection and operand forwarding for a 5-stage RV32 pipeline.
// Shadows rd/write/load of EX, MEM and WB so that it can decide stalls, flushes and bypass selects.
module pipe_hazard_unit #(
    parameter int AW       = 5,
    parameter int CNT_W    = 16,
    parameter bit BR_IN_ID = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    pipe_hazard_unit_if.slave hz_if
);

    typedef struct packed {
        logic [AW-1:0] rd;
        logic          wr;
        logic          ld;
    } trk_t;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_WB    = 2'd2
    } fwd_sel_e;

    localparam trk_t BUBBLE = '0;

    trk_t             ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    fwd_sel_e         fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic [AW-1:0]    op_rs  [2];
    logic             op_use [2];
    fwd_sel_e         idfwd  [2];
    fwd_sel_e         fwd_nxt[2];
    logic             hz, stall, flush_ifid, flush_idex, issue;

    // Register x0 is hard-wired, so a write to it never produces a value that can be consumed.
    function automatic logic match(input logic use_s, input logic [AW-1:0] rs, input trk_t t);
        return use_s && t.wr && (t.rd == rs) && (rs != '0);
    endfunction

    always_comb begin
        op_rs[0]  = hz_if.id_rs1;
        op_rs[1]  = hz_if.id_rs2;
        op_use[0] = hz_if.id_use1;
        op_use[1] = hz_if.id_use2;
    end

    // NOTE: every variable that is written in always_comb gets a default first, so that no path leaves it unassigned and infers a latch.
    always_comb begin
        hz = 1'b0;
        for (int s = 0; s < 2; s++) begin
            if (match(op_use[s], op_rs[s], ex_q) && ex_q.ld) begin
                hz = 1'b1;
            end
            if (BR_IN_ID && hz_if.id_branch &&
                (match(op_use[s], op_rs[s], ex_q) ||
                 (match(op_use[s], op_rs[s], mem_q) && mem_q.ld))) begin
                hz = 1'b1;
            end
        end
        hz = hz && hz_if.id_valid;
    end

    // A late (EX) redirect kills the wrong-path instruction, so it takes priority over that instruction's stall.
    always_comb begin
        stall      = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        if (!reset) begin
            if (BR_IN_ID) begin
                stall      = hz;
                flush_ifid = hz_if.br_taken && !hz;
            end else begin
                stall      = hz && !hz_if.br_taken;
                flush_ifid = hz_if.br_taken;
                flush_idex = hz_if.br_taken;
            end
        end
    end

    // The WB bypass hides the stale value that the register file returns while it writes at the same edge.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            idfwd[s] = FWD_NONE;
            if (BR_IN_ID && hz_if.id_branch &&
                match(op_use[s], op_rs[s], mem_q) && !mem_q.ld) begin
                idfwd[s] = FWD_EXMEM;
            end else if (match(op_use[s], op_rs[s], wb_q)) begin
                idfwd[s] = FWD_WB;
            end
        end
    end

    always_comb begin
        issue = hz_if.id_valid && !stall && !flush_idex;

        wb_d  = mem_q;
        mem_d = ex_q;
        ex_d  = BUBBLE;
        if (issue) begin
            ex_d = '{rd: hz_if.id_rd, wr: hz_if.id_regwrite, ld: hz_if.id_memread};
        end

        // The youngest producer wins. A load still in EX cannot forward, and that case is already stalled.
        for (int s = 0; s < 2; s++) begin
            fwd_nxt[s] = FWD_NONE;
            if (issue && match(op_use[s], op_rs[s], ex_q) && !ex_q.ld) begin
                fwd_nxt[s] = FWD_EXMEM;
            end else if (issue && match(op_use[s], op_rs[s], mem_q)) begin
                fwd_nxt[s] = FWD_WB;
            end
        end
        fwd_a_d = fwd_nxt[0];
        fwd_b_d = fwd_nxt[1];

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (flush_ifid && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state is written with non-blocking assignments, so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clock) begin
        if (reset) begin
            ex_q        <= BUBBLE;
            mem_q       <= BUBBLE;
            wb_q        <= BUBBLE;
            fwd_a_q     <= FWD_NONE;
            fwd_b_q     <= FWD_NONE;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz_if.stall      = stall;
    assign hz_if.flush_ifid = flush_ifid;
    assign hz_if.flush_idex = flush_idex;
    assign hz_if.fwd_a      = fwd_a_q;
    assign hz_if.fwd_b      = fwd_b_q;
    assign hz_if.idfwd_a    = idfwd[0];
    assign hz_if.idfwd_b    = idfwd[1];
    assign hz_if.stall_cnt  = stall_cnt_q;
    assign hz_if.flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: three configurations (ID branches, EX branches, 2-bit counters).
// It checks directed vector tables and then random traffic against a model of the in-flight instructions.
`timescale 1ns/1ps
module tb_pipe_hazard_unit;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
        logic       branch;
        logic       br_taken;
    } id_t;

    typedef struct packed {
        logic        stall;
        logic        flush_ifid;
        logic        flush_idex;
        logic [1:0]  idfwd_a;
        logic [1:0]  idfwd_b;
        logic [1:0]  fwd_a;
        logic [1:0]  fwd_b;
        logic [15:0] stall_cnt;
        logic [15:0] flush_cnt;
    } obs_t;

    typedef struct {
        bit  rst;
        id_t in;
        bit  stall, fi, fe;
        int  ida, idb, fa, fb, sc, fc;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    id_t  stim [3];
    obs_t obs  [3];
    obs_t snap [3];

    int n_total = 0;
    int n_pass  = 0;

    pipe_hazard_unit_if #(.AW(5), .CNT_W(16)) if0 ();
    pipe_hazard_unit_if #(.AW(5), .CNT_W(16)) if1 ();
    pipe_hazard_unit_if #(.AW(5), .CNT_W(2))  if2 ();

    pipe_hazard_unit #(.AW(5), .CNT_W(16), .BR_IN_ID(1'b1)) u_dut0 (.clock(clock), .reset(reset), .hz_if(if0));
    pipe_hazard_unit #(.AW(5), .CNT_W(16), .BR_IN_ID(1'b0)) u_dut1 (.clock(clock), .reset(reset), .hz_if(if1));
    pipe_hazard_unit #(.AW(5), .CNT_W(2),  .BR_IN_ID(1'b1)) u_dut2 (.clock(clock), .reset(reset), .hz_if(if2));

    assign if0.id_valid = stim[0].valid;    assign if1.id_valid = stim[1].valid;    assign if2.id_valid = stim[2].valid;
    assign if0.id_rs1 = stim[0].rs1;        assign if1.id_rs1 = stim[1].rs1;        assign if2.id_rs1 = stim[2].rs1;
    assign if0.id_rs2 = stim[0].rs2;        assign if1.id_rs2 = stim[1].rs2;        assign if2.id_rs2 = stim[2].rs2;
    assign if0.id_use1 = stim[0].use1;      assign if1.id_use1 = stim[1].use1;      assign if2.id_use1 = stim[2].use1;
    assign if0.id_use2 = stim[0].use2;      assign if1.id_use2 = stim[1].use2;      assign if2.id_use2 = stim[2].use2;
    assign if0.id_rd = stim[0].rd;          assign if1.id_rd = stim[1].rd;          assign if2.id_rd = stim[2].rd;
    assign if0.id_regwrite = stim[0].regwrite; assign if1.id_regwrite = stim[1].regwrite; assign if2.id_regwrite = stim[2].regwrite;
    assign if0.id_memread = stim[0].memread;   assign if1.id_memread = stim[1].memread;   assign if2.id_memread = stim[2].memread;
    assign if0.id_branch = stim[0].branch;  assign if1.id_branch = stim[1].branch;  assign if2.id_branch = stim[2].branch;
    assign if0.br_taken = stim[0].br_taken; assign if1.br_taken = stim[1].br_taken; assign if2.br_taken = stim[2].br_taken;

    assign obs[0] = {if0.stall, if0.flush_ifid, if0.flush_idex, if0.idfwd_a, if0.idfwd_b,
                     if0.fwd_a, if0.fwd_b, if0.stall_cnt, if0.flush_cnt};
    assign obs[1] = {if1.stall, if1.flush_ifid, if1.flush_idex, if1.idfwd_a, if1.idfwd_b,
                     if1.fwd_a, if1.fwd_b, if1.stall_cnt, if1.flush_cnt};
    assign obs[2] = {if2.stall, if2.flush_ifid, if2.flush_idex, if2.idfwd_a, if2.idfwd_b,
                     if2.fwd_a, if2.fwd_b, 14'd0, if2.stall_cnt, 14'd0, if2.flush_cnt};

    // Reference model: a queue of issued instructions per DUT. Index 0 is EX, 1 is MEM and 2 is WB.
    id_t         pq [3][$];
    logic [1:0]  m_fwd_a [3];
    logic [1:0]  m_fwd_b [3];
    int unsigned m_scnt  [3];
    int unsigned m_fcnt  [3];

    function automatic bit cfg_br(input int k);
        return k != 1;
    endfunction

    function automatic int unsigned cnt_max(input int k);
        return (k == 2) ? 3 : 65535;
    endfunction

    function automatic id_t stage(input int k, input int n);
        if (pq[k].size() > n) return pq[k][n];
        return '0;
    endfunction

    function automatic bit hits(input id_t c, input int s, input id_t p);
        logic [4:0] r;
        bit         u;
        r = (s == 1) ? c.rs1 : c.rs2;
        u = (s == 1) ? c.use1 : c.use2;
        return u && p.valid && p.regwrite && (p.rd == r) && (r != 5'd0);
    endfunction

    function automatic obs_t model_comb(input int k, input logic rst, input id_t c);
        obs_t       e;
        id_t        ex, mem, wb;
        bit         hz;
        logic [1:0] idf [2];
        e = '0; hz = 1'b0;
        ex = stage(k, 0); mem = stage(k, 1); wb = stage(k, 2);
        for (int s = 1; s <= 2; s++) begin
            if (hits(c, s, ex) && ex.memread) hz = 1'b1;
            if (cfg_br(k) && c.branch && (hits(c, s, ex) || (hits(c, s, mem) && mem.memread))) hz = 1'b1;
            if (cfg_br(k) && c.branch && hits(c, s, mem) && !mem.memread) idf[s-1] = 2'd1;
            else if (hits(c, s, wb))                                       idf[s-1] = 2'd2;
            else                                                            idf[s-1] = 2'd0;
        end
        hz = hz && c.valid;
        if (!rst) begin
            if (cfg_br(k)) begin
                e.stall      = hz;
                e.flush_ifid = c.br_taken && !hz;
            end else begin
                e.stall      = hz && !c.br_taken;
                e.flush_ifid = c.br_taken;
                e.flush_idex = c.br_taken;
            end
        end
        e.idfwd_a   = idf[0];
        e.idfwd_b   = idf[1];
        e.fwd_a     = m_fwd_a[k];
        e.fwd_b     = m_fwd_b[k];
        e.stall_cnt = 16'(m_scnt[k]);
        e.flush_cnt = 16'(m_fcnt[k]);
        return e;
    endfunction

    function automatic logic [1:0] fwd_of(input int k, input id_t c, input int s, input bit issue);
        id_t ex, mem;
        ex = stage(k, 0); mem = stage(k, 1);
        if (!issue) return 2'd0;
        if (hits(c, s, ex) && !ex.memread) return 2'd1;
        if (hits(c, s, mem)) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_edge(input int k, input logic rst, input id_t c, input obs_t e);
        bit issue;
        if (rst) begin
            pq[k].delete();
            m_fwd_a[k] = 2'd0; m_fwd_b[k] = 2'd0;
            m_scnt[k] = 0;     m_fcnt[k] = 0;
        end else begin
            issue = c.valid && !e.stall && !e.flush_idex;
            m_fwd_a[k] = fwd_of(k, c, 1, issue);
            m_fwd_b[k] = fwd_of(k, c, 2, issue);
            if (e.stall && m_scnt[k] < cnt_max(k)) m_scnt[k]++;
            if (e.flush_ifid && m_fcnt[k] < cnt_max(k)) m_fcnt[k]++;
            pq[k].push_front(issue ? c : id_t'('0));
            if (pq[k].size() > 3) void'(pq[k].pop_back());
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Samples the combinational outputs at the negedge, then advances one clock and samples the registered outputs at posedge+1.
    task automatic step(input bit chk);
        obs_t e [3];
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            e[k]    = model_comb(k, reset, stim[k]);
            snap[k] = obs[k];
            if (chk) begin
                check($sformatf("d%0d stall", k),      obs[k].stall,      e[k].stall);
                check($sformatf("d%0d flush_ifid", k), obs[k].flush_ifid, e[k].flush_ifid);
                check($sformatf("d%0d flush_idex", k), obs[k].flush_idex, e[k].flush_idex);
                check($sformatf("d%0d idfwd_a", k),    obs[k].idfwd_a,    e[k].idfwd_a);
                check($sformatf("d%0d idfwd_b", k),    obs[k].idfwd_b,    e[k].idfwd_b);
            end
        end
        @(posedge clock);
        for (int k = 0; k < 3; k++) model_edge(k, reset, stim[k], e[k]);
        #1;
        if (chk) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("d%0d fwd_a", k),     obs[k].fwd_a,     m_fwd_a[k]);
                check($sformatf("d%0d fwd_b", k),     obs[k].fwd_b,     m_fwd_b[k]);
                check($sformatf("d%0d stall_cnt", k), obs[k].stall_cnt, m_scnt[k]);
                check($sformatf("d%0d flush_cnt", k), obs[k].flush_cnt, m_fcnt[k]);
            end
        end
    endtask

    function automatic id_t mk(input int rd, input int rs1, input int rs2,
                               input bit u1, input bit u2, input bit wr, input bit ld,
                               input bit br, input bit tk);
        id_t i;
        i          = '0;
        i.valid    = 1'b1;
        i.rd       = 5'(rd);
        i.rs1      = 5'(rs1);
        i.rs2      = 5'(rs2);
        i.use1     = u1;
        i.use2     = u2;
        i.regwrite = wr;
        i.memread  = ld;
        i.branch   = br;
        i.br_taken = tk;
        return i;
    endfunction

    function automatic id_t alu(input int rd, input int rs1, input int rs2, input bit tk);
        return mk(rd, rs1, rs2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, tk);
    endfunction
    function automatic id_t lw(input int rd, input int rs1);
        return mk(rd, rs1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    endfunction
    function automatic id_t br(input int rs1, input int rs2, input bit tk);
        return mk(0, rs1, rs2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, tk);
    endfunction

    function automatic id_t rnd_ins();
        id_t i;
        i.valid    = ($urandom_range(0, 9) != 0);
        i.rs1      = 5'($urandom_range(0, 3));
        i.rs2      = 5'($urandom_range(0, 3));
        i.use1     = ($urandom_range(0, 3) != 0);
        i.use2     = ($urandom_range(0, 1) != 0);
        i.rd       = 5'($urandom_range(0, 3));
        i.regwrite = ($urandom_range(0, 3) != 0);
        i.memread  = i.regwrite && ($urandom_range(0, 2) == 0);
        i.branch   = ($urandom_range(0, 3) == 0);
        i.br_taken = ($urandom_range(0, 5) == 0);
        return i;
    endfunction

    vec_t tbl [$];

    task automatic add_vec(input bit rst, input id_t in, input bit st, input bit fi, input bit fe,
                           input int ida, input int idb, input int fa, input int fb,
                           input int sc, input int fc);
        vec_t v;
        v.rst = rst; v.in = in; v.stall = st; v.fi = fi; v.fe = fe;
        v.ida = ida; v.idb = idb; v.fa = fa; v.fb = fb; v.sc = sc; v.fc = fc;
        tbl.push_back(v);
    endtask

    task automatic run_table(input int k, input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            reset   = tbl[i].rst;
            stim[k] = tbl[i].in;
            step(1'b0);
            check($sformatf("%s[%0d] stall", tag, i),      snap[k].stall,      tbl[i].stall);
            check($sformatf("%s[%0d] flush_ifid", tag, i), snap[k].flush_ifid, tbl[i].fi);
            check($sformatf("%s[%0d] flush_idex", tag, i), snap[k].flush_idex, tbl[i].fe);
            check($sformatf("%s[%0d] idfwd_a", tag, i),    snap[k].idfwd_a,    tbl[i].ida);
            check($sformatf("%s[%0d] idfwd_b", tag, i),    snap[k].idfwd_b,    tbl[i].idb);
            check($sformatf("%s[%0d] fwd_a", tag, i),      obs[k].fwd_a,       tbl[i].fa);
            check($sformatf("%s[%0d] fwd_b", tag, i),      obs[k].fwd_b,       tbl[i].fb);
            check($sformatf("%s[%0d] stall_cnt", tag, i),  obs[k].stall_cnt,   tbl[i].sc);
            check($sformatf("%s[%0d] flush_cnt", tag, i),  obs[k].flush_cnt,   tbl[i].fc);
        end
        stim[k] = '0;
        tbl.delete();
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            stim[k] = '0; m_fwd_a[k] = 2'd0; m_fwd_b[k] = 2'd0; m_scnt[k] = 0; m_fcnt[k] = 0;
        end

        // BR_IN_ID=1: load-use, forwarding distances, x0 producers, ID branches, reset mid-flight.
        add_vec(1, '0,                 0,0,0, 0,0, 0,0, 0,0);
        add_vec(1, '0,                 0,0,0, 0,0, 0,0, 0,0);
        add_vec(0, '0,                 0,0,0, 0,0, 0,0, 0,0);
        add_vec(0, lw(5, 1),           0,0,0, 0,0, 0,0, 0,0);
        add_vec(0, alu(6, 5, 7, 0),    1,0,0, 0,0, 0,0, 1,0);
        add_vec(0, alu(6, 5, 7, 0),    0,0,0, 0,0, 2,0, 1,0);
        add_vec(0, alu(10, 1, 2, 0),   0,0,0, 0,0, 0,0, 1,0);
        add_vec(0, alu(11, 10, 10, 0), 0,0,0, 0,0, 1,1, 1,0);
        add_vec(0, alu(12, 1, 2, 0),   0,0,0, 0,0, 0,0, 1,0);
        add_vec(0, alu(13, 3, 4, 0),   0,0,0, 0,0, 0,0, 1,0);
        add_vec(0, alu(14, 12, 0, 0),  0,0,0, 0,0, 2,0, 1,0);
        add_vec(0, alu(15, 12, 3, 0),  0,0,0, 2,0, 0,0, 1,0);
        add_vec(0, alu(0, 1, 2, 0),    0,0,0, 0,0, 0,0, 1,0);
        add_vec(0, alu(16, 0, 0, 0),   0,0,0, 0,0, 0,0, 1,0);
        add_vec(0, lw(0, 1),           0,0,0, 0,0, 0,0, 1,0);
        add_vec(0, alu(17, 0, 0, 0),   0,0,0, 0,0, 0,0, 1,0);
        add_vec(0, alu(5, 1, 0, 0),    0,0,0, 0,0, 0,0, 1,0);
        add_vec(0, br(5, 0, 0),        1,0,0, 0,0, 0,0, 2,0);
        add_vec(0, br(5, 0, 1),        0,1,0, 1,0, 2,0, 2,1);
        add_vec(0, '0,                 0,0,0, 0,0, 0,0, 2,1);
        add_vec(0, lw(20, 1),          0,0,0, 0,0, 0,0, 2,1);
        add_vec(0, br(20, 0, 1),       1,0,0, 0,0, 0,0, 3,1);
        add_vec(0, br(20, 0, 1),       1,0,0, 0,0, 0,0, 4,1);
        add_vec(0, br(20, 0, 1),       0,1,0, 2,0, 0,0, 4,2);
        add_vec(0, '0,                 0,0,0, 0,0, 0,0, 4,2);
        add_vec(0, lw(21, 1),          0,0,0, 0,0, 0,0, 4,2);
        add_vec(1, alu(22, 21, 0, 0),  0,0,0, 0,0, 0,0, 0,0);
        add_vec(0, alu(22, 21, 0, 0),  0,0,0, 0,0, 0,0, 0,0);
        run_table(0, "id_br");

        // BR_IN_ID=0: a redirect overrides the load-use stall and kills the instruction in ID.
        add_vec(1, '0,                 0,0,0, 0,0, 0,0, 0,0);
        add_vec(0, lw(5, 1),           0,0,0, 0,0, 0,0, 0,0);
        add_vec(0, alu(6, 5, 5, 1),    0,1,1, 0,0, 0,0, 0,1);
        add_vec(0, alu(7, 6, 6, 0),    0,0,0, 0,0, 0,0, 0,1);
        add_vec(0, lw(8, 1),           0,0,0, 0,0, 0,0, 0,1);
        add_vec(0, alu(9, 8, 0, 0),    1,0,0, 0,0, 0,0, 1,1);
        add_vec(0, alu(9, 8, 0, 0),    0,0,0, 0,0, 2,0, 1,1);
        add_vec(0, br(9, 0, 0),        0,0,0, 0,0, 1,0, 1,1);
        run_table(1, "ex_br");

        // CNT_W=2: five load-use stalls saturate the stall counter at 3.
        reset = 1'b1; step(1'b0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            stim[2] = lw(5, 1);        step(1'b0);
            stim[2] = alu(6, 5, 0, 0); step(1'b0);
            check($sformatf("sat[%0d] stall", i), snap[2].stall, 1);
            check($sformatf("sat[%0d] stall_cnt", i), obs[2].stall_cnt, (i < 3) ? i + 1 : 3);
            step(1'b0);
            check($sformatf("sat[%0d] released", i), snap[2].stall, 0);
            check($sformatf("sat[%0d] fwd_a", i), obs[2].fwd_a, 2);
        end
        check("sat flush_cnt", obs[2].flush_cnt, 0);
        stim[2] = '0;

        // Random traffic on all three configurations against the reference model.
        reset = 1'b1; step(1'b1); step(1'b1);
        reset = 1'b0;
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            for (int k = 0; k < 3; k++) stim[k] = rnd_ins();
            step(1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
